// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG master: walks the TAP through reset/idle/IR-scan/DR-scan and mirrors its state.
// Optional JTAG_SEQ_STATE_CHECK_EN adds state_obs/state_err to compare the mirror against the real TAP.
module jtag_scan_sequencer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic [3:0]        tap_state
`ifdef JTAG_SEQ_STATE_CHECK_EN
  ,
  input  logic [3:0]        state_obs,
  output logic              state_err
`endif
);
  localparam int CNT_W = LEN_W + 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] OP_RESET = 2'b00, OP_IDLE = 2'b01, OP_IR = 2'b10;

  localparam logic [3:0] TLR = 4'h0, RTI = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
                         SHIFT_DR = 4'h4, EX1_DR = 4'h5, PAUSE_DR = 4'h6, EX2_DR = 4'h7,
                         UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SHIFT_IR = 4'hB,
                         EX1_IR = 4'hC, PAUSE_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF;

  typedef enum logic [1:0] {ST_INIT, ST_READY, ST_RUN} st_t;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      TLR:      tap_next = tms ? TLR    : RTI;
      RTI:      tap_next = tms ? SEL_DR : RTI;
      SEL_DR:   tap_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:   tap_next = tms ? EX1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = tms ? EX1_DR : SHIFT_DR;
      EX1_DR:   tap_next = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: tap_next = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   tap_next = tms ? UPD_DR : SHIFT_DR;
      UPD_DR:   tap_next = tms ? SEL_DR : RTI;
      SEL_IR:   tap_next = tms ? TLR    : CAP_IR;
      CAP_IR:   tap_next = tms ? EX1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = tms ? EX1_IR : SHIFT_IR;
      EX1_IR:   tap_next = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: tap_next = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   tap_next = tms ? UPD_IR : SHIFT_IR;
      default:  tap_next = tms ? SEL_DR : RTI;
    endcase
  endfunction

  st_t               st, st_nxt;
  logic [2:0]        init_cnt;
  logic [CNT_W-1:0]  cnt, len_q, len_eff, pre, last;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] sh, cap;
  logic [IDX_W-1:0]  idx;
  logic              tms_nxt, shift_bit, done, accept, in_shift, tms_seq;

  assign cmd_ready = (st == ST_READY);

  always_ff @(posedge TCK) begin
    if (!TRST) st <= ST_INIT;
    else       st <= st_nxt;
  end

  // TMS is chosen one edge ahead: the value driven at step k moves the TAP at step k+1.
  always_comb begin
    st_nxt    = st;
    tms_nxt   = 1'b0;
    shift_bit = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    len_eff   = '0;
    pre       = (op_q == OP_IR) ? CNT_W'(4) : CNT_W'(3);
    in_shift  = op_q[1] && (cnt >= pre) && (cnt < pre + len_q);
    tms_seq   = 1'b0;
    case (op_q)
      OP_RESET: last = CNT_W'(6);
      OP_IDLE:  last = len_q;
      OP_IR:    last = len_q + CNT_W'(6);
      default:  last = len_q + CNT_W'(5);
    endcase
    case (op_q)
      OP_RESET: tms_seq = (cnt < CNT_W'(5));
      OP_IDLE:  tms_seq = 1'b0;
      default: begin
        if (cnt < pre)    tms_seq = (op_q == OP_IR) ? (cnt < CNT_W'(2)) : (cnt == '0);
        else if (in_shift) tms_seq = (cnt == pre + len_q - CNT_W'(1));
        else              tms_seq = (cnt == pre + len_q);
      end
    endcase
    if (cmd_op == OP_IDLE)
      len_eff = (cmd_len == '0) ? CNT_W'(1) : CNT_W'(cmd_len);
    else if (cmd_len == '0 || CNT_W'(cmd_len) > CNT_W'(DATA_W))
      len_eff = CNT_W'(DATA_W);
    else
      len_eff = CNT_W'(cmd_len);
    case (st)
      ST_INIT: begin
        tms_nxt = (init_cnt < 3'd4);
        if (init_cnt == 3'd5) st_nxt = ST_READY;
      end
      ST_READY: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          st_nxt  = ST_RUN;
          tms_nxt = (cmd_op != OP_IDLE);
        end
      end
      default: begin
        if (cnt == last) begin
          done   = 1'b1;
          st_nxt = ST_READY;
        end else begin
          tms_nxt   = tms_seq;
          shift_bit = in_shift;
        end
      end
    endcase
  end

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tap_state <= TLR;
      init_cnt  <= '0;
      cnt       <= '0;
      op_q      <= '0;
      len_q     <= '0;
      sh        <= '0;
      cap       <= '0;
      idx       <= '0;
    end else begin
      tap_state <= tap_next(tap_state, TMS);
      TMS       <= tms_nxt;
      TDI       <= shift_bit ? sh[0] : 1'b0;
      rsp_valid <= done;
      if (shift_bit) sh <= sh >> 1;
      if (done) rsp_data <= cap;
      if (st == ST_INIT) init_cnt <= init_cnt + 3'd1;
      if (accept) begin
        cnt   <= CNT_W'(1);
        op_q  <= cmd_op;
        len_q <= len_eff;
        sh    <= cmd_data;
        cap   <= '0;
        idx   <= '0;
      end else if (st == ST_RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
      // TDO is captured on every edge the TAP spends in a shift state.
      if (st == ST_RUN && (tap_state == SHIFT_DR || tap_state == SHIFT_IR)) begin
        cap[idx] <= TDO;
        idx      <= idx + IDX_W'(1);
      end
    end
  end

`ifdef JTAG_SEQ_STATE_CHECK_EN
  always_ff @(posedge TCK) begin
    if (!TRST)                                     state_err <= 1'b0;
    else if (st != ST_INIT && state_obs != tap_state) state_err <= 1'b1;
  end
`endif

endmodule
